// File: rtl/uart_rx_frame_ctrl_if.sv
// Byte-stream / packet-stream bundle between the UART receiver, frame controller and downstream sink.
interface uart_rx_frame_ctrl_if;
  logic [7:0] data_byte;
  logic       Rx_Done;
  logic [2:0] baud_set;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;
  logic       frame_err;
  logic [1:0] err_code;

  modport master (
    output data_byte, Rx_Done, out_ready,
    input  baud_set, out_data, out_valid, out_last, frame_err, err_code
  );

  modport slave (
    input  data_byte, Rx_Done, out_ready,
    output baud_set, out_data, out_valid, out_last, frame_err, err_code
  );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// Frames UART bytes (HEADER, LEN, payload, CHK), checks the sum and streams good payloads out.
// Optional config frames reprogramming baud_set are enabled by defining UART_FRAME_CFG_EN.
module uart_rx_frame_ctrl #(
  parameter int unsigned MAX_LEN      = 16,
  parameter int unsigned TIMEOUT_CYC  = 50000,
  parameter logic [7:0]  HEADER       = 8'hAA,
`ifdef UART_FRAME_CFG_EN
  parameter logic [7:0]  CFG_HEADER   = 8'h55,
`endif
  parameter logic [2:0]  BAUD_DEFAULT = 3'd0
) (
  input logic               Clk,
  input logic               Rst_n,
  uart_rx_frame_ctrl_if.slave bus
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHK, S_SEND} state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
  logic [7:0]         sum_q, sum_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [7:0]         out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic               frame_err_q, frame_err_d;
  logic [1:0]         err_code_q, err_code_d;
  logic               buf_we;
  logic [7:0]         buf_mem [MAX_LEN];

  logic               rx;
  logic [7:0]         rx_byte;
  logic [IDX_W-1:0]   last_idx;
  logic [IDX_W-1:0]   rd_nxt;
  logic               tmo_hit;
  logic               in_frame;

`ifdef UART_FRAME_CFG_EN
  logic               is_cfg_q, is_cfg_d;
  logic [2:0]         baud_q, baud_d;
`endif

  assign rx       = bus.Rx_Done;
  assign rx_byte  = bus.data_byte;
  assign last_idx = IDX_W'(len_q - LEN_W'(1));
  assign rd_nxt   = rd_idx_q + IDX_W'(1);
  assign tmo_hit  = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
  assign in_frame = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHK);

  // State register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    sum_d       = sum_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    buf_we      = 1'b0;
    tmo_d       = (rx || !in_frame || tmo_hit) ? '0 : tmo_q + TMO_W'(1);
`ifdef UART_FRAME_CFG_EN
    is_cfg_d    = is_cfg_q;
    baud_d      = baud_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (rx) begin
          if (rx_byte == HEADER) begin
            state_d = S_LEN;
`ifdef UART_FRAME_CFG_EN
            is_cfg_d = 1'b0;
          end else if (rx_byte == CFG_HEADER) begin
            state_d  = S_LEN;
            is_cfg_d = 1'b1;
`endif
          end
        end
      end

      S_LEN: begin
        if (rx) begin
          if (rx_byte == 8'd0 || 32'(rx_byte) > MAX_LEN
`ifdef UART_FRAME_CFG_EN
              || (is_cfg_q && rx_byte != 8'd1)
`endif
             ) begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
            err_code_d  = 2'd1;
          end else begin
            len_d    = LEN_W'(rx_byte);
            sum_d    = rx_byte;
            wr_idx_d = '0;
            state_d  = S_PAYLOAD;
          end
        end
      end

      S_PAYLOAD: begin
        if (rx) begin
          buf_we = 1'b1;
          sum_d  = sum_q + rx_byte;
          if (wr_idx_q == last_idx) state_d = S_CHK;
          else                      wr_idx_d = wr_idx_q + IDX_W'(1);
        end
      end

      S_CHK: begin
        if (rx) begin
          if (rx_byte == sum_q) begin
`ifdef UART_FRAME_CFG_EN
            if (is_cfg_q) begin
              baud_d  = buf_mem[0][2:0];
              state_d = S_IDLE;
            end else begin
`endif
              rd_idx_d    = '0;
              out_data_d  = buf_mem[0];
              out_last_d  = (last_idx == '0);
              out_valid_d = 1'b1;
              state_d     = S_SEND;
`ifdef UART_FRAME_CFG_EN
            end
`endif
          end else begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
            err_code_d  = 2'd2;
          end
        end
      end

      S_SEND: begin
        // A byte arriving while draining is dropped; the stream itself carries on.
        if (rx) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'd0;
        end
        if (out_valid_q && bus.out_ready) begin
          if (rd_idx_q == last_idx) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = S_IDLE;
          end else begin
            rd_idx_d   = rd_nxt;
            out_data_d = buf_mem[rd_nxt];
            out_last_d = (rd_nxt == last_idx);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Inter-byte timeout; a byte in the expiring cycle takes precedence.
    if (in_frame && !rx && tmo_hit) begin
      state_d     = S_IDLE;
      frame_err_d = 1'b1;
      err_code_d  = 2'd3;
    end
  end

  // Datapath and output registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      len_q       <= '0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      sum_q       <= '0;
      tmo_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      len_q       <= len_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      sum_q       <= sum_d;
      tmo_q       <= tmo_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (buf_we) buf_mem[wr_idx_q] <= rx_byte;
  end

`ifdef UART_FRAME_CFG_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      is_cfg_q <= 1'b0;
      baud_q   <= BAUD_DEFAULT;
    end else begin
      is_cfg_q <= is_cfg_d;
      baud_q   <= baud_d;
    end
  end
  assign bus.baud_set = baud_q;
`else
  assign bus.baud_set = BAUD_DEFAULT;
`endif

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.frame_err = frame_err_q;
  assign bus.err_code  = err_code_q;

endmodule
